// File: rtl/game_sequencer.sv
// rtl/game_sequencer.sv - dino runner play-state controller: idle/run/hit/over, BCD score, speed level.
// Optional GAME_SEQ_HISCORE_EN adds a persistent hi_score output.
module game_sequencer #(
  parameter int SCORE_DIGITS     = 4,
  parameter int FRAMES_PER_POINT = 6,
  parameter int POINTS_PER_LEVEL = 100,
  parameter int MAX_LEVEL        = 7,
  parameter int OVER_HOLD_FRAMES = 60
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              btn,
  input  logic                              frame_tick,
  input  logic                              collision,
  output logic                              run_en,
  output logic                              jump_en,
  output logic                              field_clr,
  output logic [$clog2(MAX_LEVEL+2)-1:0]    speed,
  output logic [4*SCORE_DIGITS-1:0]         score,
`ifdef GAME_SEQ_HISCORE_EN
  output logic [4*SCORE_DIGITS-1:0]         hi_score,
`endif
  output logic                              game_over,
  output logic [1:0]                        state
);

  localparam int SW  = 4 * SCORE_DIGITS;
  localparam int SPW = $clog2(MAX_LEVEL + 2);
  localparam int LW  = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL + 1) : 1;
  localparam int FW  = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
  localparam int PW  = (POINTS_PER_LEVEL > 1) ? $clog2(POINTS_PER_LEVEL) : 1;
  localparam int HW  = $clog2(OVER_HOLD_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HIT  = 2'b10,
    S_OVER = 2'b11
  } state_t;

  state_t          cur, nxt;
  logic            btn_q;
  logic            btn_rise;
  logic [FW-1:0]   frame_cnt;
  logic [PW-1:0]   pts_cnt;
  logic [LW-1:0]   level;
  logic [HW-1:0]   hold_cnt;
  logic            start;
  logic            frame_inc;
  logic            point;
  logic            hold_inc;

  // Increment with saturation: a carry out of the top digit means all nines.
  function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    logic          carry;
    r     = s;
    carry = 1'b1;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (s[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = s[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return carry ? s : r;
  endfunction

  assign btn_rise = btn & ~btn_q;
  assign state    = cur;

  always_ff @(posedge clk) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt       = cur;
    start     = 1'b0;
    frame_inc = 1'b0;
    point     = 1'b0;
    hold_inc  = 1'b0;
    case (cur)
      S_IDLE: begin
        if (btn_rise) begin
          nxt   = S_RUN;
          start = 1'b1;
        end
      end
      S_RUN: begin
        if (collision) begin
          nxt = S_HIT;
        end else if (frame_tick) begin
          frame_inc = 1'b1;
          point     = (frame_cnt == FW'(FRAMES_PER_POINT - 1));
        end
      end
      S_HIT: nxt = S_OVER;
      S_OVER: begin
        if (btn_rise && hold_cnt == HW'(OVER_HOLD_FRAMES)) begin
          nxt   = S_RUN;
          start = 1'b1;
        end else if (frame_tick && hold_cnt != HW'(OVER_HOLD_FRAMES)) begin
          hold_inc = 1'b1;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q     <= 1'b0;
      run_en    <= 1'b0;
      jump_en   <= 1'b0;
      field_clr <= 1'b0;
      game_over <= 1'b0;
      speed     <= SPW'(1);
      score     <= '0;
      frame_cnt <= '0;
      pts_cnt   <= '0;
      level     <= '0;
      hold_cnt  <= '0;
    end else begin
      btn_q     <= btn;
      run_en    <= (nxt == S_RUN);
      jump_en   <= (nxt == S_RUN);
      field_clr <= start;
      game_over <= (nxt == S_OVER);
      speed     <= SPW'(level) + SPW'(1);

      if (start) begin
        score     <= '0;
        frame_cnt <= '0;
        pts_cnt   <= '0;
        level     <= '0;
      end else if (frame_inc) begin
        if (point) begin
          frame_cnt <= '0;
          score     <= bcd_inc(score);
          if (pts_cnt == PW'(POINTS_PER_LEVEL - 1)) begin
            pts_cnt <= '0;
            if (level != LW'(MAX_LEVEL)) level <= level + LW'(1);
          end else begin
            pts_cnt <= pts_cnt + PW'(1);
          end
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end

      if (cur == S_HIT || start) hold_cnt <= '0;
      else if (hold_inc)         hold_cnt <= hold_cnt + HW'(1);
    end
  end

`ifdef GAME_SEQ_HISCORE_EN
  // Packed BCD with valid digits orders the same as its binary value, MSD first.
  always_ff @(posedge clk) begin
    if (rst)                               hi_score <= '0;
    else if (cur == S_HIT && score > hi_score) hi_score <= score;
  end
`endif

endmodule

// File: tb/tb_game_sequencer.sv
// tb/tb_game_sequencer.sv - randomized bench for game_sequencer against a score/level reference model.
module tb_game_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, btn, frame_tick, collision;

  logic        a_run_en, a_jump_en, a_field_clr, a_game_over;
  logic [3:0]  a_speed;
  logic [15:0] a_score;
  logic [1:0]  a_state;
  logic        b_run_en, b_jump_en, b_field_clr, b_game_over;
  logic [3:0]  b_speed;
  logic [15:0] b_score;
  logic [1:0]  b_state;
`ifdef GAME_SEQ_HISCORE_EN
  logic [15:0] a_hi, b_hi;
`endif

  game_sequencer dut_a (
    .clk(clk), .rst(rst), .btn(btn), .frame_tick(frame_tick), .collision(collision),
    .run_en(a_run_en), .jump_en(a_jump_en), .field_clr(a_field_clr), .speed(a_speed),
    .score(a_score),
`ifdef GAME_SEQ_HISCORE_EN
    .hi_score(a_hi),
`endif
    .game_over(a_game_over), .state(a_state)
  );

  game_sequencer #(.FRAMES_PER_POINT(1), .POINTS_PER_LEVEL(4)) dut_b (
    .clk(clk), .rst(rst), .btn(btn), .frame_tick(frame_tick), .collision(collision),
    .run_en(b_run_en), .jump_en(b_jump_en), .field_clr(b_field_clr), .speed(b_speed),
    .score(b_score),
`ifdef GAME_SEQ_HISCORE_EN
    .hi_score(b_hi),
`endif
    .game_over(b_game_over), .state(b_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: the game is described by the ticks counted in the current run;
  // points, score and level all follow from it by arithmetic.
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_HIT = 2, ST_OVER = 3;
  localparam int HOLD = 60, MAXL = 7;
  int fpp[2] = '{6, 1};
  int ppl[2] = '{100, 4};
  int m_st[2], m_ticks[2], m_hold[2], m_spd[2], m_hi[2];
  bit m_btnq[2], m_fclr[2];

  function automatic int pts_of(input int d);
    int p;
    p = m_ticks[d] / fpp[d];
    return (p > 9999) ? 9999 : p;
  endfunction

  function automatic int lvl_of(input int d);
    int l;
    l = (m_ticks[d] / fpp[d]) / ppl[d];
    return (l > MAXL) ? MAXL : l;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step(input int d, input bit r, input bit b, input bit t, input bit c);
    bit rise;
    int spd_n;
    if (r) begin
      m_st[d] = ST_IDLE; m_ticks[d] = 0; m_hold[d] = 0; m_spd[d] = 1;
      m_hi[d] = 0; m_btnq[d] = 0; m_fclr[d] = 0;
      return;
    end
    rise    = b && !m_btnq[d];
    spd_n   = lvl_of(d) + 1;
    m_fclr[d] = 0;
    case (m_st[d])
      ST_IDLE: if (rise) begin m_st[d] = ST_RUN; m_ticks[d] = 0; m_fclr[d] = 1; end
      ST_RUN: begin
        if (c)      m_st[d] = ST_HIT;
        else if (t) m_ticks[d]++;
      end
      ST_HIT: begin
        if (pts_of(d) > m_hi[d]) m_hi[d] = pts_of(d);
        m_st[d] = ST_OVER; m_hold[d] = 0;
      end
      default: begin
        if (rise && m_hold[d] == HOLD) begin
          m_st[d] = ST_RUN; m_ticks[d] = 0; m_fclr[d] = 1;
        end else if (t && m_hold[d] < HOLD) begin
          m_hold[d]++;
        end
      end
    endcase
    m_btnq[d] = b;
    m_spd[d]  = spd_n;
  endtask

  task automatic compare_dut(input string p, input int d, input logic [1:0] st, input logic re,
                             input logic je, input logic fc, input logic go,
                             input logic [3:0] sp, input logic [15:0] sc);
    check_eq({p, ".state"},     32'(st), 32'(m_st[d]));
    check_eq({p, ".run_en"},    32'(re), 32'(m_st[d] == ST_RUN));
    check_eq({p, ".jump_en"},   32'(je), 32'(m_st[d] == ST_RUN));
    check_eq({p, ".field_clr"}, 32'(fc), 32'(m_fclr[d]));
    check_eq({p, ".game_over"}, 32'(go), 32'(m_st[d] == ST_OVER));
    check_eq({p, ".speed"},     32'(sp), 32'(m_spd[d]));
    check_eq({p, ".score"},     32'(sc), 32'(to_bcd(pts_of(d))));
  endtask

  task automatic cyc(input bit r, input bit b, input bit t, input bit c);
    rst = r; btn = b; frame_tick = t; collision = c;
    @(posedge clk);
    model_step(0, r, b, t, c);
    model_step(1, r, b, t, c);
    #1;
    compare_dut("a", 0, a_state, a_run_en, a_jump_en, a_field_clr, a_game_over, a_speed, a_score);
    compare_dut("b", 1, b_state, b_run_en, b_jump_en, b_field_clr, b_game_over, b_speed, b_score);
`ifdef GAME_SEQ_HISCORE_EN
    check_eq("a.hi_score", 32'(a_hi), 32'(to_bcd(m_hi[0])));
    check_eq("b.hi_score", 32'(b_hi), 32'(to_bcd(m_hi[1])));
`endif
  endtask

  task automatic ticks(input int n, input bit b, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        for (int j = 0; j < g; j++) cyc(0, b, 0, 0);
      end
      cyc(0, b, 1, 0);
    end
  endtask

  task automatic restart_after_hold;
    ticks(HOLD, 0, 1);
    cyc(0, 1, 0, 0);
    check_eq("restart.state", 32'(a_state), 32'h1);
  endtask

  initial begin
    rst = 1'b1; btn = 1'b1; frame_tick = 1'b0; collision = 1'b0;

    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
    check_eq("rst.state", 32'(a_state), 32'h0);
    check_eq("rst.speed", 32'(a_speed), 32'h1);
    check_eq("rst.score", 32'(a_score), 32'h0);

    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check_eq("start.field_clr", 32'(a_field_clr), 32'h1);
    check_eq("start.state",     32'(a_state),     32'h1);
    check_eq("start.run_en",    32'(a_run_en),    32'h1);

    ticks(4, 1, 0);
    check_eq("start.field_clr_off", 32'(a_field_clr), 32'h0);
    cyc(0, 1, 0, 0);
    check_eq("ramp.speed2", 32'(b_speed), 32'h2);
    ticks(24, 1, 0);
    cyc(0, 1, 0, 0);
    check_eq("ramp.speed8", 32'(b_speed), 32'h8);
    ticks(12, 1, 0);
    cyc(0, 1, 0, 0);
    check_eq("ramp.speed_sat", 32'(b_speed), 32'h8);
    check_eq("ramp.score40",   32'(b_score), 32'h0040);
    ticks(20, 1, 1);
    check_eq("score.60ticks", 32'(a_score), 32'h0010);

    cyc(0, 1, 1, 1);
    check_eq("hit.score", 32'(a_score), 32'h0010);
    check_eq("hit.state", 32'(a_state), 32'h2);
    cyc(0, 1, 0, 0);
    check_eq("over.state", 32'(a_state), 32'h3);

    ticks(59, 0, 1);
    cyc(0, 1, 0, 0);
    check_eq("hold.early_rise", 32'(a_state), 32'h3);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check_eq("hold.btn_held", 32'(a_state), 32'h3);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    check_eq("hold.restart_state", 32'(a_state),     32'h1);
    check_eq("hold.restart_clr",   32'(a_field_clr), 32'h1);
    check_eq("hold.restart_score", 32'(a_score),     32'h0);

    ticks(150, 1, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 0);
`ifdef GAME_SEQ_HISCORE_EN
    check_eq("hi.game1", 32'(a_hi), 32'h0025);
`endif
    restart_after_hold();
    ticks(72, 1, 1);
    cyc(0, 1, 0, 1);
    cyc(0, 1, 0, 0);
    check_eq("game2.score", 32'(a_score), 32'h0012);
`ifdef GAME_SEQ_HISCORE_EN
    check_eq("hi.game2", 32'(a_hi), 32'h0025);
`endif
    restart_after_hold();

    ticks(10000, 1, 0);
    check_eq("sat.score", 32'(b_score), 32'h9999);
    ticks(20, 1, 0);
    check_eq("sat.hold", 32'(b_score), 32'h9999);

    cyc(1, 1, 0, 0);
    check_eq("rst2.state", 32'(a_state), 32'h0);
`ifdef GAME_SEQ_HISCORE_EN
    check_eq("hi.rst", 32'(a_hi), 32'h0);
`endif

    begin
      bit b;
      b = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 7) == 0) b = ~b;
        cyc(($urandom_range(0, 499) == 0), b, ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 39) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
